// File: rtl/onehot_bitscan_pkg.sv
// Shared types for the one-hot/multi-hot bit-scan encoder.
package onehot_bitscan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_bitscan_encoder_if.sv
// Input-vector and output-index handshake bundle for the bit-scan encoder.
interface onehot_bitscan_encoder_if #(
  parameter int BINARY_BITS = 3
);
  localparam int WIDTH = 2 ** BINARY_BITS;

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic [BINARY_BITS-1:0] out_binary;
  logic                   out_last;
  logic                   out_zero;

  // Producer of vectors / consumer of indices.
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_binary, out_last, out_zero
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_binary, out_last, out_zero
  );
endinterface

// File: rtl/lsb_onehot_encoder.sv
// Combinational lowest-set-bit isolator and encoder.
module lsb_onehot_encoder #(
  parameter int BINARY_BITS = 3
) (
  input  logic [2**BINARY_BITS-1:0] vec,
  output logic [2**BINARY_BITS-1:0] lsb_onehot,
  output logic [BINARY_BITS-1:0]    lsb_binary,
  output logic                      any,
  output logic                      multi
);
  localparam int WIDTH = 2 ** BINARY_BITS;

  // Isolate the lowest set bit (vec & -vec) and OR-encode its position.
  always_comb begin
    lsb_onehot = vec & (~vec + WIDTH'(1));
    lsb_binary = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (lsb_onehot[i]) lsb_binary = lsb_binary | BINARY_BITS'(i);
    end
    any   = |vec;
    multi = |(vec & ~lsb_onehot);
  end
endmodule

// File: rtl/onehot_bitscan_encoder.sv
// Serialises a multi-hot vector into binary indices, lowest bit first.
// in_ready depends combinationally on out_ready so a new vector can be
// taken in the same cycle the last beat retires.
module onehot_bitscan_encoder
  import onehot_bitscan_pkg::*;
#(
  parameter int BINARY_BITS = 3
) (
  input logic                       clk,
  input logic                       resetn,
  input logic                       flush,
  onehot_bitscan_encoder_if.slave   bus
);
  localparam int WIDTH = 2 ** BINARY_BITS;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_pending;
  logic                   r_zero;

  logic [WIDTH-1:0]       w_lsb_onehot;
  logic [BINARY_BITS-1:0] w_lsb_binary;
  logic                   w_any;
  logic                   w_multi;
  logic                   w_scan;
  logic                   w_last;
  logic                   w_out_fire;
  logic                   w_in_fire;

  lsb_onehot_encoder #(
    .BINARY_BITS (BINARY_BITS)
  ) u_lsb (
    .vec        (r_pending),
    .lsb_onehot (w_lsb_onehot),
    .lsb_binary (w_lsb_binary),
    .any        (w_any),
    .multi      (w_multi)
  );

  // Output beat and handshake decode from the registered state.
  always_comb begin
    w_scan         = (r_state == SCAN);
    w_last         = w_scan && (r_zero || !w_multi);
    w_out_fire     = w_scan && bus.out_ready;
    bus.out_valid  = w_scan;
    bus.out_binary = (w_scan && w_any) ? w_lsb_binary : '0;
    bus.out_last   = w_last;
    bus.out_zero   = w_scan && r_zero;
    bus.in_ready   = !flush && (!w_scan || (bus.out_ready && w_last));
    w_in_fire      = bus.in_valid && bus.in_ready;
  end

  // FSM, pending vector and zero flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_zero    <= 1'b0;
    end else if (flush) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_zero    <= 1'b0;
    end else if (w_in_fire) begin
      r_state   <= SCAN;
      r_pending <= bus.in_vec;
      r_zero    <= (bus.in_vec == '0);
    end else if (w_out_fire) begin
      if (w_last) begin
        r_state   <= IDLE;
        r_pending <= '0;
        r_zero    <= 1'b0;
      end else begin
        r_pending <= r_pending & ~w_lsb_onehot;
      end
    end
  end
endmodule

// File: tb/tb_onehot_bitscan_encoder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-of-expected-beats reference model.
module tb_onehot_bitscan_encoder;
  localparam int BB = 3;
  localparam int W  = 2 ** BB;

  typedef struct {
    int idx;
    bit last;
    bit zero;
  } beat_t;

  logic clk;
  logic resetn;
  logic flush;

  onehot_bitscan_encoder_if #(.BINARY_BITS(BB)) bus ();

  onehot_bitscan_encoder #(.BINARY_BITS(BB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beats for one vector: set-bit positions ascending; one zero beat for 0.
  task automatic push_vec(input logic [W-1:0] v);
    int n = 0;
    if (v == '0) begin
      q.push_back('{idx: 0, last: 1'b1, zero: 1'b1});
      return;
    end
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        q.push_back('{idx: i, last: 1'b0, zero: 1'b0});
        n++;
      end
    end
    q[q.size()-1].last = 1'b1;
  endtask

  task automatic check_outputs(input bit fl, input bit ordy);
    bit busy = (q.size() != 0);
    chk("out_valid",  int'(bus.out_valid),  int'(busy));
    chk("out_binary", int'(bus.out_binary), busy ? q[0].idx : 0);
    chk("out_last",   int'(bus.out_last),   busy ? int'(q[0].last) : 0);
    chk("out_zero",   int'(bus.out_zero),   busy ? int'(q[0].zero) : 0);
    chk("in_ready",   int'(bus.in_ready),   int'(!fl && (!busy || (ordy && q[0].last))));
  endtask

  // One cycle: drive at negedge, check just after, then advance the model.
  task automatic step(input bit iv, input logic [W-1:0] vec, input bit ordy, input bit fl);
    bit busy;
    bit acc;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_vec    = vec;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    check_outputs(fl, ordy);
    busy = (q.size() != 0);
    acc  = iv && !fl && (!busy || (ordy && q[0].last));
    if (fl) begin
      q.delete();
    end else begin
      if (busy && ordy) void'(q.pop_front());
      if (acc) push_vec(vec);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * W + 4; i++) step(1'b0, $urandom(), 1'b1, 1'b0);
  endtask

  initial begin
    resetn        = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    #12;
    check_outputs(1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Three-bit vector: beats 2,5,7.
    step(1'b1, 8'hA4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'hFF, 1'b1, 1'b0);

    // All-zero vector: single zero beat.
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Full vector with toggling out_ready.
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, 8'h00, (i % 2) == 0, 1'b0);

    // Back-to-back 8'h80 then 8'h03, offered continuously.
    step(1'b1, 8'h80, 1'b1, 1'b0);
    step(1'b1, 8'h03, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush mid-scan, with a handshake attempt that must be discarded.
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b1);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-scan of 8'hAA after beat 1.
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    q.delete();
    #1;
    check_outputs(1'b0, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 1'b1, 1'b0);

    // Randomized traffic with back-pressure, sparse flush and varied vectors.
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] v;
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = W'(1) << $urandom_range(0, W - 1);
        default: v = W'($urandom());
      endcase
      step($urandom_range(0, 1) == 1, v, $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
